memaccess: RTL and testbench
============================

Name: memaccess

Overview:
Memory-access pipeline stage between execute and writeback in the Venus core. It fills the data-memory slot the core leaves open.
- Takes EX results plus a load/store request and drives a synchronous single-port data memory (same timing as DP_mem32x64k: address/write sampled at the clock edge, Q valid the following cycle).
- Forwards the writeback bundle to WB using the core's v/stall handshake.

Parameters:
ADDR_W, 16, word-address width (64k words)
WORD_W, 32, data word width
RD_W, 5, register number width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
v_i  in  1  EX result valid
stall_o  out  1  back-pressure to EX
wb_i  in  1  EX requests register writeback
rd_num_i  in  RD_W  destination register
rd_data_i  in  WORD_W  ALU result
mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mem_addr_i  in  ADDR_W  data word address
mem_wdata_i  in  WORD_W  store data
mem_a_o  out  ADDR_W  memory address
mem_w_o  out  1  memory write enable
mem_d_o  out  WORD_W  memory write data
mem_q_i  in  WORD_W  memory read data (valid cycle after address)
v_o  out  1  result valid to WB
stall_i  in  1  back-pressure from WB
wb_o  out  1  writeback enable to WB
rd_num_o  out  RD_W  destination register to WB
rd_data_o  out  WORD_W  writeback data to WB

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid=1 and stall=0. accept = v_i & ~stall_o. Data held while v_o=1 & stall_i=1 must not change.
- Output register: out_v, out_wb, out_rd, out_data. v_o=out_v, wb_o=out_wb, rd_num_o=out_rd, rd_data_o=out_data.
- FSM states:
  - IDLE: no load pending.
  - LOAD: load issued last cycle; mem_q_i valid this cycle.
- Memory drive (combinational):
  - mem_a_o = mem_addr_i.
  - mem_d_o = mem_wdata_i.
  - mem_w_o = accept & (mem_op_i==10) & ~rst. No write ever occurs without accept.
- stall_o = (out_v & stall_i) | (state==LOAD).
- On accept of none/reserved op:
  - out <= {1, wb_i, rd_num_i, rd_data_i}; state stays IDLE.
  - Latency 1 cycle.
- On accept of store:
  - out <= {1, 0, rd_num_i, rd_data_i}. wb forced 0; store still produces v_o for retirement.
  - Memory written at the accept edge.
- On accept of load:
  - out_v <= 0; pending wb/rd latched internally; state <= LOAD.
- In LOAD:
  - out <= {1, pend_wb, pend_rd, mem_q_i}; state <= IDLE.
  - Captured unconditionally; out_v is 0 in LOAD, so no overwrite is possible.
  - Load latency 2 cycles, one bubble to EX.
- If out_v & ~stall_i & ~accept: out_v <= 0 (drained).
- Back-to-back non-loads: one per cycle.
- Reset (async, any state, including mid-load):
  - state=IDLE, out_v=0, out_wb=0, out_rd=0, out_data=0, pending cleared.
  - stall_o=0 after reset deasserts if stall_i=0.
  - mem_w_o=0 while rst=1.
  - A load interrupted by reset is discarded.

Optional Feature:
Macro MEMACCESS_LOAD_FWD_EN.
- Without it: behaviour as above (load = 2 cycles, 1 bubble).
- With it:
  - In LOAD, v_o=1, wb_o=pend_wb, rd_num_o=pend_rd, rd_data_o=mem_q_i, driven combinationally.
  - stall_o = stall_i & (out_v | state==LOAD).
  - If stall_i=0 in LOAD: the load retires and a new accept is allowed the same cycle. Load latency 1, no bubble.
  - If stall_i=1 in LOAD: mem_q_i is captured into the out register (out_v=1), state <= IDLE, and normal hold applies.

Test Plan:
1. Reset then three ALU ops (wb=1, rd=1,2,3, data 0x11,0x22,0x33), stall_i=0 -> v_o on three consecutive cycles starting 1 cycle after each accept, data 0x11/0x22/0x33 in order, stall_o stays 0.
2. Store addr 0x0040 data 0xDEADBEEF, then load rd=7 addr 0x0040 -> mem_w_o pulses once; load gives v_o with rd_num_o=7, rd_data_o=0xDEADBEEF 2 cycles after accept; stall_o=1 for exactly 1 cycle (with MEMACCESS_LOAD_FWD_EN: 1 cycle, no stall).
3. Hold stall_i=1 for 4 cycles with v_o=1 and v_i=1 presenting a store -> outputs frozen, stall_o=1, mem_w_o=0 throughout; store is written on the first cycle after stall_i drops.
4. Load issued, stall_i=1 during the LOAD cycle (FWD build) -> data captured and held; after release v_o delivers the correct mem_q_i value exactly once.
5. Assert rst during LOAD state -> v_o=0 and stall_o=0 immediately (async); no v_o for the aborted load after reset release.
6. Store with wb_i=1, rd=9 -> v_o=1, wb_o=0; mem_op_i=11 with wb_i=1 -> treated as ALU op, wb_o=1, mem_w_o=0.

Source files
------------

// File: rtl/memaccess.sv
// memaccess: memory-access stage between EX and WB.
// Drives a synchronous single-port data memory (Q valid the cycle after the address) and
// forwards the writeback bundle to WB over a v/stall handshake.
// Optional feature: define MEMACCESS_LOAD_FWD_EN to present load data combinationally in the
// LOAD cycle, which removes the load bubble.
`timescale 1ns/1ps
module memaccess #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              v_i,
   output logic              stall_o,
   input  logic              wb_i,
   input  logic [RD_W-1:0]   rd_num_i,
   input  logic [WORD_W-1:0] rd_data_i,
   input  logic [1:0]        mem_op_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [WORD_W-1:0] mem_wdata_i,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_w_o,
   output logic [WORD_W-1:0] mem_d_o,
   input  logic [WORD_W-1:0] mem_q_i,
   output logic              v_o,
   input  logic              stall_i,
   output logic              wb_o,
   output logic [RD_W-1:0]   rd_num_o,
   output logic [WORD_W-1:0] rd_data_o
);

   typedef enum logic [0:0] {StIdle, StLoad} state_e;

   localparam logic [1:0] OpLoad  = 2'b01;
   localparam logic [1:0] OpStore = 2'b10;

   state_e              state_q, state_d;
   logic                out_v_q, out_v_d;
   logic                out_wb_q, out_wb_d;
   logic [RD_W-1:0]     out_rd_q, out_rd_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                pend_wb_q, pend_wb_d;
   logic [RD_W-1:0]     pend_rd_q, pend_rd_d;

   logic accept;
   logic is_load;
   logic is_store;
   logic load_capture;

   // Handshake, back-pressure and memory drive
   always_comb begin
`ifdef MEMACCESS_LOAD_FWD_EN
      // Load data is forwarded straight out, so LOAD only stalls when WB stalls.
      stall_o      = stall_i & (out_v_q | (state_q == StLoad));
      load_capture = (state_q == StLoad) & stall_i;
`else
      stall_o      = (out_v_q & stall_i) | (state_q == StLoad);
      load_capture = (state_q == StLoad);
`endif
      accept   = v_i & ~stall_o;
      is_load  = (mem_op_i == OpLoad);
      is_store = (mem_op_i == OpStore);
      mem_a_o  = mem_addr_i;
      mem_d_o  = mem_wdata_i;
      mem_w_o  = accept & is_store & ~rst;
   end

   // Output bundle to WB
   always_comb begin
      v_o       = out_v_q;
      wb_o      = out_wb_q;
      rd_num_o  = out_rd_q;
      rd_data_o = out_data_q;
`ifdef MEMACCESS_LOAD_FWD_EN
      if (state_q == StLoad) begin
         v_o       = 1'b1;
         wb_o      = pend_wb_q;
         rd_num_o  = pend_rd_q;
         rd_data_o = mem_q_i;
      end
`endif
   end

   // Next-state: load completion, accept of a new op, or drain of the output register
   always_comb begin
      state_d    = state_q;
      out_v_d    = out_v_q;
      out_wb_d   = out_wb_q;
      out_rd_d   = out_rd_q;
      out_data_d = out_data_q;
      pend_wb_d  = pend_wb_q;
      pend_rd_d  = pend_rd_q;
      if (load_capture) begin
         // out_v is 0 while in LOAD, so this never overwrites an unretired result.
         state_d    = StIdle;
         out_v_d    = 1'b1;
         out_wb_d   = pend_wb_q;
         out_rd_d   = pend_rd_q;
         out_data_d = mem_q_i;
      end else begin
         // Only reachable in LOAD with forwarding: the load retired this cycle.
         if (state_q == StLoad) begin
            state_d = StIdle;
         end
         if (accept) begin
            if (is_load) begin
               state_d   = StLoad;
               out_v_d   = 1'b0;
               pend_wb_d = wb_i;
               pend_rd_d = rd_num_i;
            end else begin
               out_v_d    = 1'b1;
               out_wb_d   = wb_i & ~is_store;
               out_rd_d   = rd_num_i;
               out_data_d = rd_data_i;
            end
         end else if (out_v_q && !stall_i) begin
            out_v_d = 1'b0;
         end
      end
   end

   // State and output registers; reset discards any in-flight load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         out_v_q    <= 1'b0;
         out_wb_q   <= 1'b0;
         out_rd_q   <= '0;
         out_data_q <= '0;
         pend_wb_q  <= 1'b0;
         pend_rd_q  <= '0;
      end else begin
         state_q    <= state_d;
         out_v_q    <= out_v_d;
         out_wb_q   <= out_wb_d;
         out_rd_q   <= out_rd_d;
         out_data_q <= out_data_d;
         pend_wb_q  <= pend_wb_d;
         pend_rd_q  <= pend_rd_d;
      end
   end

endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess: scoreboard bench for memaccess with a synchronous 64k x 32 memory model.
`timescale 1ns/1ps
module tb_memaccess;

   typedef struct packed {
      logic        wb;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk, rst;
   logic        v_i, stall_o, wb_i, stall_i;
   logic [4:0]  rd_num_i;
   logic [31:0] rd_data_i, mem_wdata_i, mem_d_o, mem_q_i;
   logic [1:0]  mem_op_i;
   logic [15:0] mem_addr_i, mem_a_o;
   logic        mem_w_o, v_o, wb_o;
   logic [4:0]  rd_num_o;
   logic [31:0] rd_data_o;

   logic [31:0] mem [0:65535];
   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   memaccess dut (
      .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .wb_i(wb_i),
      .rd_num_i(rd_num_i), .rd_data_i(rd_data_i), .mem_op_i(mem_op_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_a_o(mem_a_o),
      .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i), .v_o(v_o),
      .stall_i(stall_i), .wb_o(wb_o), .rd_num_o(rd_num_o), .rd_data_o(rd_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory: read returns old data, Q valid next cycle
   always @(posedge clk) begin
      if (mem_w_o) mem[mem_a_o] <= mem_d_o;
      mem_q_i <= mem[mem_a_o];
   end

   // Scoreboard: every WB transfer pops one expected result
   always @(negedge clk) begin
      if (!rst && v_o && !stall_i) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected_v_o: got wb=%0b rd=%0d data=%h, required no transfer",
                     wb_o, rd_num_o, rd_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({wb_o, rd_num_o, rd_data_o} !== e) begin
               miscompares++;
               $display("FAIL sb_result: got wb=%0b rd=%0d data=%h, required wb=%0b rd=%0d data=%h",
                        wb_o, rd_num_o, rd_data_o, e.wb, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic wb, input logic [4:0] rd,
                        input logic [31:0] data, input logic [15:0] addr,
                        input logic [31:0] wdata);
      v_i = v; mem_op_i = op; wb_i = wb; rd_num_i = rd;
      rd_data_i = data; mem_addr_i = addr; mem_wdata_i = wdata;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_i = 1'b0;
      drive(1'b1, 2'b10, 1'b1, 5'd3, 32'h1, 16'h0010, 32'h5555_AAAA);
      @(negedge clk);
      vectors++;
      if ({v_o, wb_o, rd_num_o, rd_data_o, stall_o} !== 40'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%0b wb=%0b rd=%0d data=%h stall=%0b, required all 0",
                  v_o, wb_o, rd_num_o, rd_data_o, stall_o);
      end
      vectors++;
      if (mem_w_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mem_w: got %0b, required 0", mem_w_o);
      end
      tick();
      rst = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      @(negedge clk);
      vectors++;
      if ({stall_o, v_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release: got stall=%0b v=%0b, required 0 0", stall_o, v_o);
      end
      tick();
   endtask

   task automatic test_alu_stream();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 2'b00, 1'b1, 5'(i), 32'(i * 32'h11), 16'h0, 32'h0);
         exp_q.push_back({1'b1, 5'(i), 32'(i * 32'h11)});
         @(negedge clk);
         vectors++;
         if (stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_stall[%0d]: got %0b, required 0", i, stall_o);
         end
         if (i > 1) begin
            vectors++;
            if ({v_o, rd_num_o} !== {1'b1, 5'(i - 1)}) begin
               miscompares++;
               $display("FAIL alu_v_o[%0d]: got v=%0b rd=%0d, required v=1 rd=%0d",
                        i, v_o, rd_num_o, i - 1);
            end
         end
         tick();
      end
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      @(negedge clk);
      vectors++;
      if ({v_o, rd_num_o, rd_data_o} !== {1'b1, 5'd3, 32'h33}) begin
         miscompares++;
         $display("FAIL alu_last: got v=%0b rd=%0d data=%h, required v=1 rd=3 data=33",
                  v_o, rd_num_o, rd_data_o);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (v_o !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_drain: got v=%0b, required 0", v_o);
      end
      tick();
   endtask

   task automatic test_store_load();
      drive(1'b1, 2'b10, 1'b1, 5'd4, 32'h44, 16'h0040, 32'hDEADBEEF);
      exp_q.push_back({1'b0, 5'd4, 32'h44});
      @(negedge clk);
      vectors++;
      if ({mem_w_o, stall_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL st_issue: got mem_w=%0b stall=%0b, required 1 0", mem_w_o, stall_o);
      end
      tick();
      drive(1'b1, 2'b01, 1'b1, 5'd7, 32'h77, 16'h0040, 32'h0);
      exp_q.push_back({1'b1, 5'd7, 32'hDEADBEEF});
      @(negedge clk);
      vectors++;
      if ({mem_w_o, stall_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL ld_issue: got mem_w=%0b stall=%0b, required 0 0", mem_w_o, stall_o);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      @(negedge clk);
      vectors++;
`ifdef MEMACCESS_LOAD_FWD_EN
      if ({v_o, rd_num_o, stall_o, mem_w_o} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
`else
      if ({v_o, rd_num_o, stall_o, mem_w_o} !== {1'b0, rd_num_o, 1'b1, 1'b0}) begin
`endif
         miscompares++;
         $display("FAIL ld_cycle1: got v=%0b rd=%0d stall=%0b mem_w=%0b",
                  v_o, rd_num_o, stall_o, mem_w_o);
      end
      tick();
      @(negedge clk);
      vectors++;
`ifdef MEMACCESS_LOAD_FWD_EN
      if ({v_o, stall_o} !== 2'b00) begin
`else
      if ({v_o, rd_num_o, stall_o} !== {1'b1, 5'd7, 1'b0}) begin
`endif
         miscompares++;
         $display("FAIL ld_cycle2: got v=%0b rd=%0d stall=%0b", v_o, rd_num_o, stall_o);
      end
      tick();
   endtask

   task automatic test_stall_hold();
      drive(1'b1, 2'b00, 1'b1, 5'd5, 32'h55, 16'h0, 32'h0);
      exp_q.push_back({1'b1, 5'd5, 32'h55});
      tick();
      stall_i = 1'b1;
      drive(1'b1, 2'b10, 1'b1, 5'd6, 32'h66, 16'h0080, 32'hCAFEF00D);
      exp_q.push_back({1'b0, 5'd6, 32'h66});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if ({v_o, wb_o, rd_num_o, rd_data_o, stall_o, mem_w_o} !==
             {1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL hold[%0d]: got v=%0b wb=%0b rd=%0d data=%h stall=%0b mem_w=%0b, required 1 1 5 55 1 0",
                     c, v_o, wb_o, rd_num_o, rd_data_o, stall_o, mem_w_o);
         end
         tick();
      end
      stall_i = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_w_o, stall_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL hold_release: got mem_w=%0b stall=%0b, required 1 0", mem_w_o, stall_o);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      tick();
   endtask

   task automatic test_load_stall();
      drive(1'b1, 2'b01, 1'b1, 5'd8, 32'h88, 16'h0080, 32'h0);
      exp_q.push_back({1'b1, 5'd8, 32'hCAFEF00D});
      @(negedge clk);
      vectors++;
      if (stall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL lds_issue: got stall=%0b, required 0", stall_o);
      end
      tick();
      // Move the address so a stale combinational path would show the wrong data
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0000, 32'h0);
      stall_i = 1'b1;
      @(negedge clk);
      vectors++;
`ifdef MEMACCESS_LOAD_FWD_EN
      if ({v_o, rd_data_o, stall_o} !== {1'b1, 32'hCAFEF00D, 1'b1}) begin
`else
      if ({v_o, stall_o} !== 2'b01) begin
`endif
         miscompares++;
         $display("FAIL lds_load_cycle: got v=%0b data=%h stall=%0b", v_o, rd_data_o, stall_o);
      end
      tick();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vectors++;
         if ({v_o, rd_num_o, rd_data_o, stall_o} !== {1'b1, 5'd8, 32'hCAFEF00D, 1'b1}) begin
            miscompares++;
            $display("FAIL lds_held[%0d]: got v=%0b rd=%0d data=%h stall=%0b, required 1 8 cafef00d 1",
                     c, v_o, rd_num_o, rd_data_o, stall_o);
         end
         tick();
      end
      stall_i = 1'b0;
      tick();
      @(negedge clk);
      vectors++;
      if (v_o !== 1'b0) begin
         miscompares++;
         $display("FAIL lds_once: got v=%0b, required 0", v_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      drive(1'b1, 2'b01, 1'b1, 5'd10, 32'hA0, 16'h0040, 32'h0);
      @(negedge clk);
      vectors++;
      if (stall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rml_issue: got stall=%0b, required 0", stall_o);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      rst = 1'b1;
      #1;
      vectors++;
      if ({v_o, stall_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL rml_async: got v=%0b stall=%0b, required 0 0", v_o, stall_o);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({v_o, stall_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL rml_after[%0d]: got v=%0b stall=%0b, required 0 0", c, v_o, stall_o);
         end
         tick();
      end
   endtask

   task automatic test_store_wb_reserved();
      drive(1'b1, 2'b10, 1'b1, 5'd9, 32'h99, 16'h0100, 32'h1234_5678);
      exp_q.push_back({1'b0, 5'd9, 32'h99});
      @(negedge clk);
      vectors++;
      if (mem_w_o !== 1'b1) begin
         miscompares++;
         $display("FAIL swb_mem_w: got %0b, required 1", mem_w_o);
      end
      tick();
      drive(1'b1, 2'b11, 1'b1, 5'd12, 32'hABC, 16'h0040, 32'h0);
      exp_q.push_back({1'b1, 5'd12, 32'hABC});
      @(negedge clk);
      vectors++;
      if ({mem_w_o, v_o, wb_o, rd_num_o} !== {1'b0, 1'b1, 1'b0, 5'd9}) begin
         miscompares++;
         $display("FAIL swb_store_out: got mem_w=%0b v=%0b wb=%0b rd=%0d, required 0 1 0 9",
                  mem_w_o, v_o, wb_o, rd_num_o);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      @(negedge clk);
      vectors++;
      if ({v_o, wb_o, rd_num_o} !== {1'b1, 1'b1, 5'd12}) begin
         miscompares++;
         $display("FAIL swb_reserved_out: got v=%0b wb=%0b rd=%0d, required 1 1 12",
                  v_o, wb_o, rd_num_o);
      end
      tick();
      // Reserved op must not have touched 0x0040
      drive(1'b1, 2'b01, 1'b1, 5'd13, 32'h0, 16'h0040, 32'h0);
      exp_q.push_back({1'b1, 5'd13, 32'hDEADBEEF});
      tick();
      drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 16'h0, 32'h0);
      repeat (3) tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      test_reset();
      test_alu_stream();
      test_store_load();
      test_stall_hold();
      test_load_stall();
      test_reset_mid_load();
      test_store_wb_reserved();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d results never delivered, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
